game_ctrl_param: RTL and testbench

Parametrised game-flow controller for the typing game. It runs the SELECT, COUNTDOWN, INGAME, PAUSE and FINISH flow. It adds a pause state, an internal game timer, a word counter with automatic finish, and configurable option tables and volume range. It sits between the debounced/one-pulsed buttons and the display, audio and LED drivers.

---
 rtl/game_ctrl_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_game_ctrl_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_param.sv
// game_ctrl_param: typing-game flow controller (select, countdown, play,
// pause, finish) with game timer, word counter, option tables and volume.
module game_ctrl_param #(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned SEC_TICKS = 10,
  parameter int unsigned CD_TICKS  = 30,
  parameter int unsigned VOL_MAX   = 5,
  parameter int unsigned VOL_RST   = 3,
  parameter int unsigned TIME_STEP = 15,
  parameter int unsigned TIME_OPTS = 6,
  parameter int unsigned WORD_STEP = 25,
  parameter int unsigned WORD_OPTS = 4,
  parameter int unsigned VW        = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sel_up,
  input  logic               sel_down,
  input  logic               vol_up,
  input  logic               vol_down,
  input  logic               pause,
  input  logic               mode_sw,
  input  logic               word_done,
  input  logic               finish,
  output logic               mode,
  output logic [2:0]         state,
  output logic [VW-1:0]      target,
  output logic [VW-1:0]      remaining,
  output logic               timeout,
  output logic [VOL_MAX-1:0] vol,
  output logic [15:0]        led
);

  localparam int unsigned LW   = $clog2(VOL_MAX + 1);
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW   = (CD_TICKS > 0) ? $clog2(CD_TICKS + 1) : 1;
  localparam int unsigned SW   = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int unsigned BDIV = SEC_TICKS * TICK_DIV;
  localparam int unsigned BW   = (BDIV > 1) ? $clog2(BDIV) : 1;

  localparam logic [VW-1:0] T_STEP = VW'(TIME_STEP);
  localparam logic [VW-1:0] T_MAX  = VW'(TIME_STEP * TIME_OPTS);
  localparam logic [VW-1:0] W_STEP = VW'(WORD_STEP);
  localparam logic [VW-1:0] W_MAX  = VW'(WORD_STEP * WORD_OPTS);

  typedef enum logic [2:0] {
    S_SELECT    = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_INGAME    = 3'd2,
    S_PAUSE     = 3'd3,
    S_FINISH    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [VW-1:0]     time_q, time_d;
  logic [VW-1:0]     word_q, word_d;
  logic [VW-1:0]     rem_q, rem_d;
  logic              timeout_q, timeout_d;
  logic [LW-1:0]     level_q, level_d;
  logic [VOL_MAX-1:0] vol_q, vol_d;
  logic [15:0]       led_q, led_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     cd_q, cd_d;
  logic [SW-1:0]     sec_q, sec_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic              tick;

  // Thermometer code: low 'lvl' bits set.
  function automatic logic [VOL_MAX-1:0] therm(input logic [LW-1:0] lvl);
    logic [VOL_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < VOL_MAX; i++) begin
      if (i < 32'(lvl)) t[i] = 1'b1;
    end
    return t;
  endfunction

  // Status LED pattern: volume bar filled from the top of the low field,
  // state indication in the upper byte.
  function automatic logic [15:0] led_calc(input state_e st, input logic [LW-1:0] lvl,
                                           input logic [CW-1:0] cd, input logic blk);
    logic [15:0] l;
    l = '0;
    for (int unsigned i = 0; i < VOL_MAX; i++) begin
      if (i + 32'(lvl) >= VOL_MAX) l[i] = 1'b1;
    end
    case (st)
      // bit (15-k) lit while k < ceil(8*cd/CD_TICKS), i.e. k*CD_TICKS < 8*cd
      S_COUNTDOWN: begin
        for (int unsigned j = 8; j < 16; j++) begin
          if ((15 - j) * CD_TICKS < 8 * 32'(cd)) l[j] = 1'b1;
        end
      end
      S_PAUSE:  l[15:8] = {8{blk}};
      S_FINISH: l[15:8] = 8'hFF;
      default:  ;
    endcase
    return l;
  endfunction

  // One option-table step with wrap in both directions.
  function automatic logic [VW-1:0] opt_step(input logic [VW-1:0] cur, input logic up,
                                             input logic [VW-1:0] stp, input logic [VW-1:0] top);
    if (up) return (cur >= top) ? stp : cur + stp;
    else    return (cur <= stp) ? top : cur - stp;
  endfunction

  assign state     = state_q;
  assign mode      = mode_q;
  assign target    = mode_q ? word_q : time_q;
  assign remaining = rem_q;
  assign timeout   = timeout_q;
  assign vol       = vol_q;
  assign led       = led_q;

  // Volume level with saturation; vol/led follow the level one cycle later.
  always_comb begin
    level_d = level_q;
    if (vol_up && !vol_down && (level_q < LW'(VOL_MAX))) begin
      level_d = level_q + LW'(1);
    end else if (vol_down && !vol_up && (level_q != '0)) begin
      level_d = level_q - LW'(1);
    end
    vol_d = therm(level_q);
    led_d = led_calc(state_q, level_q, cd_q, blink_q);
  end

  // Free-running blink source so the pause indication moves while the tick
  // prescaler is frozen.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BDIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Game flow: prescaler, countdown, timer/word counting and state changes.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    time_d    = time_q;
    word_d    = word_q;
    rem_d     = rem_q;
    timeout_d = timeout_q;
    cd_d      = cd_q;
    sec_d     = sec_q;
    presc_d   = presc_q;
    tick      = 1'b0;

    case (state_q)
      S_COUNTDOWN, S_INGAME: begin
        if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: ;
      default: presc_d = '0;
    endcase

    case (state_q)
      S_SELECT: begin
        mode_d = mode_sw;
        if (sel_up ^ sel_down) begin
          if (mode_sw) word_d = opt_step(word_q, sel_up, W_STEP, W_MAX);
          else         time_d = opt_step(time_q, sel_up, T_STEP, T_MAX);
        end
        if (start) begin
          state_d   = S_COUNTDOWN;
          cd_d      = CW'(CD_TICKS);
          rem_d     = mode_sw ? word_q : time_q;
          timeout_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (cd_q == '0) begin
          state_d = S_INGAME;
          sec_d   = '0;
        end else if (tick) begin
          cd_d = cd_q - CW'(1);
        end
      end
      S_INGAME: begin
        if (!mode_q) begin
          if (tick) begin
            if (sec_q == SW'(SEC_TICKS - 1)) begin
              sec_d = '0;
              if (rem_q != '0) rem_d = rem_q - VW'(1);
            end else begin
              sec_d = sec_q + SW'(1);
            end
          end
        end else if (word_done && (rem_q != '0)) begin
          rem_d = rem_q - VW'(1);
        end
        if (rem_q == '0) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end else if (finish) begin
          state_d   = S_FINISH;
          timeout_d = 1'b0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start)      state_d = S_SELECT;
        else if (pause) state_d = S_INGAME;
      end
      S_FINISH: begin
        if (start) state_d = S_SELECT;
      end
      default: state_d = S_SELECT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SELECT;
      mode_q      <= 1'b0;
      time_q      <= T_STEP;
      word_q      <= W_STEP;
      rem_q       <= '0;
      timeout_q   <= 1'b0;
      level_q     <= LW'(VOL_RST);
      vol_q       <= therm(LW'(VOL_RST));
      led_q       <= led_calc(S_SELECT, LW'(VOL_RST), CW'(CD_TICKS), 1'b0);
      presc_q     <= '0;
      cd_q        <= CW'(CD_TICKS);
      sec_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      time_q      <= time_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      timeout_q   <= timeout_d;
      level_q     <= level_d;
      vol_q       <= vol_d;
      led_q       <= led_d;
      presc_q     <= presc_d;
      cd_q        <= cd_d;
      sec_q       <= sec_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl_param.sv
// Directed bench for game_ctrl_param with an expected-value queue.
module tb_game_ctrl_param;

  localparam int unsigned VW      = 7;
  localparam int unsigned VOL_MAX = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, sel_up = 1'b0, sel_down = 1'b0;
  logic vol_up = 1'b0, vol_down = 1'b0, pause = 1'b0;
  logic mode_sw = 1'b0, word_done = 1'b0, finish = 1'b0;
  logic               mode;
  logic [2:0]         state;
  logic [VW-1:0]      target, remaining;
  logic               timeout;
  logic [VOL_MAX-1:0] vol;
  logic [15:0]        led;

  game_ctrl_param #(
    .TICK_DIV (4),
    .SEC_TICKS(2),
    .CD_TICKS (3),
    .VOL_MAX  (VOL_MAX),
    .VW       (VW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sel_up   (sel_up),
    .sel_down (sel_down),
    .vol_up   (vol_up),
    .vol_down (vol_down),
    .pause    (pause),
    .mode_sw  (mode_sw),
    .word_done(word_done),
    .finish   (finish),
    .mode     (mode),
    .state    (state),
    .target   (target),
    .remaining(remaining),
    .timeout  (timeout),
    .vol      (vol),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t        sb[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input int unsigned v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_v(input int unsigned obs);
    exp_t e;
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $error("FAIL sb_empty: observed %0d, expected a queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nerr++;
        $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pulse_vol(input logic up);
    if (up) vol_up = 1'b1; else vol_down = 1'b1;
    step();
    vol_up = 1'b0; vol_down = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rem_changed, saw_on, saw_off;

    // Reset values
    step(2);
    expect_v("rst_state", 0); expect_v("rst_mode", 0); expect_v("rst_target", 15);
    expect_v("rst_rem", 0); expect_v("rst_timeout", 0); expect_v("rst_vol", 7);
    expect_v("rst_led", 16'h001C);
    rst = 1'b0;
    step();
    check_v(32'(state)); check_v(32'(mode)); check_v(32'(target));
    check_v(32'(remaining)); check_v(32'(timeout)); check_v(32'(vol)); check_v(32'(led));

    // Volume saturation, simultaneous buttons, one-cycle latency, floor
    for (int i = 0; i < 7; i++) pulse_vol(1'b1);
    expect_v("vol_sat", 31); expect_v("led_vol_sat", 31);
    check_v(32'(vol)); check_v(32'(led[4:0]));
    vol_up = 1'b1; vol_down = 1'b1;
    expect_v("vol_both", 31);
    step();
    vol_up = 1'b0; vol_down = 1'b0;
    step();
    check_v(32'(vol));
    vol_down = 1'b1;
    expect_v("vol_lat0", 31); expect_v("vol_lat1", 15); expect_v("led_lvl4", 5'b11110);
    step();
    vol_down = 1'b0;
    check_v(32'(vol));
    step();
    check_v(32'(vol)); check_v(32'(led[4:0]));
    for (int i = 0; i < 6; i++) pulse_vol(1'b0);
    expect_v("vol_floor", 0); expect_v("led_vol_floor", 0);
    check_v(32'(vol)); check_v(32'(led[4:0]));
    for (int i = 0; i < 5; i++) pulse_vol(1'b1);
    expect_v("vol_back", 31);
    check_v(32'(vol));

    // Option tables
    mode_sw = 1'b0; sel_down = 1'b1;
    expect_v("t_down_wrap", 90);
    step(); sel_down = 1'b0;
    check_v(32'(target));
    sel_up = 1'b1;
    expect_v("t_up_wrap", 15);
    step(); sel_up = 1'b0;
    check_v(32'(target));
    mode_sw = 1'b1;
    expect_v("mode_word", 1); expect_v("w_target", 25);
    step();
    check_v(32'(mode)); check_v(32'(target));
    sel_down = 1'b1;
    expect_v("w_down_wrap", 100);
    step(); sel_down = 1'b0;
    check_v(32'(target));
    mode_sw = 1'b0;
    expect_v("t_untouched", 15);
    step();
    check_v(32'(target));
    sel_up = 1'b1; sel_down = 1'b1;
    expect_v("sel_both", 15);
    step(); sel_up = 1'b0; sel_down = 1'b0;
    check_v(32'(target));

    // Time-mode game to timeout
    start = 1'b1;
    expect_v("cd_state", 1); expect_v("cd_rem", 15); expect_v("cd_timeout", 0);
    step(); start = 1'b0;
    check_v(32'(state)); check_v(32'(remaining)); check_v(32'(timeout));
    expect_v("cd_last_state", 1); expect_v("cd_led_1of3", 8'hE0);
    step(12);
    check_v(32'(state)); check_v(32'(led[15:8]));
    expect_v("ingame_entry", 2);
    step();
    check_v(32'(state));
    expect_v("rem_before_dec", 15);
    step(6);
    check_v(32'(remaining));
    expect_v("rem_first_dec", 14);
    step();
    check_v(32'(remaining));
    expect_v("rem_zero", 0); expect_v("ingame_at_zero", 2);
    step(112);
    check_v(32'(remaining)); check_v(32'(state));
    expect_v("fin_state", 4); expect_v("fin_timeout", 1);
    step();
    check_v(32'(state)); check_v(32'(timeout));
    expect_v("fin_led", 8'hFF);
    step();
    check_v(32'(led[15:8]));
    start = 1'b1;
    expect_v("fin_to_select", 0); expect_v("timeout_hold", 1); expect_v("rem_hold", 0);
    step(); start = 1'b0;
    check_v(32'(state)); check_v(32'(timeout)); check_v(32'(remaining));

    // Word-mode game to timeout
    mode_sw = 1'b1;
    step();
    sel_up = 1'b1;
    expect_v("w_up_wrap", 25);
    step(); sel_up = 1'b0;
    check_v(32'(target));
    start = 1'b1;
    expect_v("w_cd_state", 1); expect_v("w_cd_rem", 25);
    step(); start = 1'b0;
    check_v(32'(state)); check_v(32'(remaining));
    for (int i = 0; i < 3; i++) begin
      word_done = 1'b1; step(); word_done = 1'b0; step();
    end
    expect_v("wd_in_cd_ignored", 25);
    check_v(32'(remaining));
    expect_v("w_ingame", 2);
    step(7);
    check_v(32'(state));
    for (int i = 0; i < 24; i++) begin
      word_done = 1'b1; step(); word_done = 1'b0; step();
    end
    expect_v("wd_rem1", 1); expect_v("wd_still_ingame", 2);
    check_v(32'(remaining)); check_v(32'(state));
    word_done = 1'b1;
    expect_v("wd_rem0", 0);
    step(); word_done = 1'b0;
    check_v(32'(remaining));
    expect_v("wd_fin_state", 4); expect_v("wd_fin_timeout", 1);
    step();
    check_v(32'(state)); check_v(32'(timeout));
    start = 1'b1; step(); start = 1'b0;

    // Pause mid-second and resume with residual count
    mode_sw = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    expect_v("p_ingame", 2);
    step(13);
    check_v(32'(state));
    expect_v("p_rem_pre", 14);
    step(9);
    check_v(32'(remaining));
    pause = 1'b1;
    expect_v("p_state", 3);
    step(); pause = 1'b0;
    check_v(32'(state));
    rem_changed = 1'b0; saw_on = 1'b0; saw_off = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (remaining != 7'd14) rem_changed = 1'b1;
      if (led[15:8] == 8'hFF) saw_on = 1'b1;
      if (led[15:8] == 8'h00) saw_off = 1'b1;
    end
    expect_v("p_rem_frozen", 0); expect_v("p_blink_on", 1); expect_v("p_blink_off", 1);
    check_v(32'(rem_changed)); check_v(32'(saw_on)); check_v(32'(saw_off));
    pause = 1'b1;
    expect_v("resume_state", 2);
    step(); pause = 1'b0;
    check_v(32'(state));
    expect_v("resume_hold", 14);
    step(4);
    check_v(32'(remaining));
    expect_v("resume_dec", 13);
    step();
    check_v(32'(remaining));

    // Abort from pause, start beats pause
    pause = 1'b1;
    expect_v("p2_state", 3);
    step(); pause = 1'b0;
    check_v(32'(state));
    start = 1'b1; pause = 1'b1;
    expect_v("abort_select", 0);
    step(); start = 1'b0; pause = 1'b0;
    check_v(32'(state));

    // Reset during countdown
    start = 1'b1; step(); start = 1'b0;
    expect_v("cd_before_rst", 1);
    step(5);
    check_v(32'(state));
    rst = 1'b1;
    expect_v("rr_state", 0); expect_v("rr_vol", 7); expect_v("rr_target", 15); expect_v("rr_rem", 0);
    step();
    check_v(32'(state)); check_v(32'(vol)); check_v(32'(target)); check_v(32'(remaining));
    rst = 1'b0;
    step();

    // External finish request
    start = 1'b1; step(); start = 1'b0;
    expect_v("x_ingame", 2);
    step(13);
    check_v(32'(state));
    finish = 1'b1;
    expect_v("x_fin_state", 4); expect_v("x_fin_timeout", 0);
    step(); finish = 1'b0;
    check_v(32'(state)); check_v(32'(timeout));

    nvec++;
    assert (sb.size() === 0) else begin
      nerr++;
      $error("FAIL sb_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
